// File: rtl/dma_slot_arbiter.sv
// Chip-bus CCK slot arbiter: assigns each beam slot to refresh, a fixed-slot DMA
// channel, bitplane/copper/blitter by priority, or the CPU with starvation relief.
module dma_slot_arbiter #(
  parameter int SLOT_MAX   = 226,
  parameter int CPU_STARVE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slot_en,
  input  logic [7:0] hpos,
  input  logic       dma_en,
  input  logic       dsk_req,
  input  logic [3:0] aud_req,
  input  logic [7:0] spr_req,
  input  logic       bpl_req,
  input  logic       cop_req,
  input  logic       blt_req,
  input  logic       bltpri,
  input  logic       cpu_req,
  output logic [3:0] owner,
  output logic [2:0] owner_idx,
  output logic       gnt_bpl,
  output logic       gnt_cop,
  output logic       gnt_blt,
  output logic       gnt_cpu,
  output logic [2:0] cpu_wait
);

  typedef enum logic [3:0] {
    OWN_IDLE = 4'd0,
    OWN_REF  = 4'd1,
    OWN_DSK  = 4'd2,
    OWN_AUD  = 4'd3,
    OWN_SPR  = 4'd4,
    OWN_BPL  = 4'd5,
    OWN_COP  = 4'd6,
    OWN_BLT  = 4'd7,
    OWN_CPU  = 4'd8
  } owner_e;

  localparam logic [7:0] SLOT_LAST  = 8'(SLOT_MAX);
  localparam logic [2:0] STARVE_MAX = 3'(CPU_STARVE);

  owner_e     owner_q, owner_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] wait_q, wait_d;

  logic       ref_slot, dsk_slot, aud_slot, spr_slot, in_range;
  logic [7:0] aud_off, spr_off;
  logic [1:0] aud_n;
  logic [2:0] spr_n;

  // Slot map decode: audio and sprite slots are odd positions at a fixed stride,
  // so the channel number falls straight out of the offset from the first slot.
  always_comb begin
    aud_off  = hpos - 8'h0D;
    spr_off  = hpos - 8'h15;
    aud_n    = aud_off[2:1];
    spr_n    = spr_off[4:2];
    ref_slot = (hpos == 8'h01) || (hpos == 8'h03) || (hpos == 8'h05) || (hpos == 8'hE2);
    dsk_slot = (hpos == 8'h07) || (hpos == 8'h09) || (hpos == 8'h0B);
    aud_slot = hpos[0] && (hpos >= 8'h0D) && (hpos <= 8'h13);
    spr_slot = hpos[0] && (hpos >= 8'h15) && (hpos <= 8'h33);
    in_range = (hpos <= SLOT_LAST);
  end

  // NOTE: every variable driven here gets a default first so no path can infer a latch.
  always_comb begin
    owner_d = OWN_IDLE;
    idx_d   = 3'd0;
    wait_d  = wait_q;

    if (ref_slot) begin
      owner_d = OWN_REF;
    end else if (dsk_slot && dsk_req && dma_en) begin
      owner_d = OWN_DSK;
    end else if (aud_slot && aud_req[aud_n] && dma_en) begin
      owner_d = OWN_AUD;
      idx_d   = {1'b0, aud_n};
    end else if (spr_slot && bpl_req && dma_en) begin
      owner_d = OWN_BPL;
    end else if (spr_slot && spr_req[spr_n] && dma_en) begin
      owner_d = OWN_SPR;
      idx_d   = spr_n;
    end else if (bpl_req && dma_en) begin
      owner_d = OWN_BPL;
    end else if (cop_req && dma_en && in_range && !hpos[0]) begin
      owner_d = OWN_COP;
    end else if (blt_req && dma_en) begin
      // Starved CPU steals the blitter's slot unless the blitter is marked nasty.
      if (cpu_req && !bltpri && (wait_q == STARVE_MAX)) owner_d = OWN_CPU;
      else                                              owner_d = OWN_BLT;
    end else if (cpu_req) begin
      owner_d = OWN_CPU;
    end

    if (!cpu_req || owner_d == OWN_CPU) begin
      wait_d = 3'd0;
    end else if (owner_d == OWN_BLT && wait_q != STARVE_MAX) begin
      wait_d = wait_q + 3'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_IDLE;
      idx_q   <= 3'd0;
      wait_q  <= 3'd0;
    end else if (slot_en) begin
      owner_q <= owner_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
    end
  end

  assign owner     = owner_q;
  assign owner_idx = idx_q;
  assign cpu_wait  = wait_q;
  assign gnt_bpl   = (owner_q == OWN_BPL);
  assign gnt_cop   = (owner_q == OWN_COP);
  assign gnt_blt   = (owner_q == OWN_BLT);
  assign gnt_cpu   = (owner_q == OWN_CPU);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0({gnt_bpl, gnt_cop, gnt_blt, gnt_cpu}));

endmodule

// File: tb/tb_dma_slot_arbiter.sv
// Directed scoreboard bench for dma_slot_arbiter: each strobed slot pushes its
// expected owner/index/wait, which is popped and compared one clk later.
module tb_dma_slot_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       slot_en = 1'b0;
  logic [7:0] hpos = 8'd0;
  logic       dma_en = 1'b0;
  logic       dsk_req = 1'b0;
  logic [3:0] aud_req = 4'd0;
  logic [7:0] spr_req = 8'd0;
  logic       bpl_req = 1'b0;
  logic       cop_req = 1'b0;
  logic       blt_req = 1'b0;
  logic       bltpri = 1'b0;
  logic       cpu_req = 1'b0;
  logic [3:0] owner;
  logic [2:0] owner_idx;
  logic       gnt_bpl, gnt_cop, gnt_blt, gnt_cpu;
  logic [2:0] cpu_wait;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] own;
    logic [2:0] idx;
    logic [2:0] wcnt;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  dma_slot_arbiter dut (
    .clk(clk), .reset(reset), .slot_en(slot_en), .hpos(hpos), .dma_en(dma_en),
    .dsk_req(dsk_req), .aud_req(aud_req), .spr_req(spr_req), .bpl_req(bpl_req),
    .cop_req(cop_req), .blt_req(blt_req), .bltpri(bltpri), .cpu_req(cpu_req),
    .owner(owner), .owner_idx(owner_idx), .gnt_bpl(gnt_bpl), .gnt_cop(gnt_cop),
    .gnt_blt(gnt_blt), .gnt_cpu(gnt_cpu), .cpu_wait(cpu_wait)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_exp(input exp_t e);
    logic [3:0] g;
    g = {e.own == 4'd5, e.own == 4'd6, e.own == 4'd7, e.own == 4'd8};
    return {18'd0, g, e.own, e.idx, e.wcnt};
  endfunction

  function automatic logic [31:0] pack_obs();
    return {18'd0, gnt_bpl, gnt_cop, gnt_blt, gnt_cpu, owner, owner_idx, cpu_wait};
  endfunction

  task automatic check_out(input string tag, input logic [3:0] own,
                           input logic [2:0] idx, input logic [2:0] wcnt);
    exp_t e;
    e = '{own: own, idx: idx, wcnt: wcnt};
    check(tag, pack_obs(), pack_exp(e));
  endtask

  // Called at a negedge; strobes one slot and compares the registered result.
  task automatic slot(input string tag, input logic [7:0] h, input logic [3:0] own,
                      input logic [2:0] idx, input logic [2:0] wcnt);
    hpos    = h;
    slot_en = 1'b1;
    sb_q.push_back('{own: own, idx: idx, wcnt: wcnt});
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check({tag, "_underflow"}, 32'd1, 32'd0);
    end else begin
      check(tag_q.pop_front(), pack_obs(), pack_exp(sb_q.pop_front()));
    end
  endtask

  task automatic idle(input int n);
    slot_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_reqs();
    dsk_req = 1'b0; aud_req = 4'd0; spr_req = 8'd0; bpl_req = 1'b0;
    cop_req = 1'b0; blt_req = 1'b0; bltpri = 1'b0; cpu_req = 1'b0;
  endtask

  logic [3:0] starve_own[8] = '{4'd7, 4'd7, 4'd7, 4'd8, 4'd7, 4'd7, 4'd7, 4'd8};
  logic [2:0] starve_wt[8]  = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};

  initial begin
    repeat (2) @(negedge clk);
    check_out("reset_state", 4'd0, 3'd0, 3'd0);
    reset = 1'b0;
    @(negedge clk);

    // Refresh independent of dma_en; everything else but CPU is gated off.
    dma_en = 1'b0;
    dsk_req = 1'b1; aud_req = 4'hF; spr_req = 8'hFF; bpl_req = 1'b1;
    cop_req = 1'b1; blt_req = 1'b1; cpu_req = 1'b1;
    slot("ref_dma_off", 8'h03, 4'd1, 3'd0, 3'd0);
    slot("cpu_dma_off", 8'h04, 4'd8, 3'd0, 3'd0);
    slot("dsk_dma_off", 8'h07, 4'd8, 3'd0, 3'd0);
    cpu_req = 1'b0;
    idle(3);
    check_out("hold_no_strobe", 4'd8, 3'd0, 3'd0);

    // Fixed slots and bitplane override.
    clear_reqs();
    dma_en = 1'b1;
    dsk_req = 1'b1;
    slot("disk", 8'h07, 4'd2, 3'd0, 3'd0);
    dsk_req = 1'b0; bpl_req = 1'b1;
    slot("disk_unclaimed_bpl", 8'h09, 4'd5, 3'd0, 3'd0);
    aud_req = 4'b0001;
    slot("aud0_over_bpl", 8'h0D, 4'd3, 3'd0, 3'd0);
    bpl_req = 1'b0; aud_req = 4'b0100;
    slot("aud2", 8'h11, 4'd3, 3'd2, 3'd0);
    slot("aud3_unclaimed", 8'h13, 4'd0, 3'd0, 3'd0);
    aud_req = 4'd0; spr_req = 8'h20;
    slot("spr5", 8'h29, 4'd4, 3'd5, 3'd0);
    slot("spr5_b", 8'h2B, 4'd4, 3'd5, 3'd0);
    bpl_req = 1'b1;
    slot("spr5_bpl", 8'h29, 4'd5, 3'd0, 3'd0);
    spr_req = 8'h80; bpl_req = 1'b0;
    slot("spr7", 8'h33, 4'd4, 3'd7, 3'd0);
    idle(1);

    // Copper parity.
    clear_reqs();
    cop_req = 1'b1; blt_req = 1'b1;
    slot("cop_even", 8'h40, 4'd6, 3'd0, 3'd0);
    slot("blt_odd", 8'h41, 4'd7, 3'd0, 3'd0);
    idle(1);

    // Starvation relief, back-to-back strobes.
    clear_reqs();
    blt_req = 1'b1; cpu_req = 1'b1;
    for (int i = 0; i < 8; i++)
      slot($sformatf("starve_%0d", i), 8'h40 + 8'(i), starve_own[i], 3'd0, starve_wt[i]);
    idle(1);
    bltpri = 1'b1;
    for (int i = 0; i < 8; i++)
      slot($sformatf("nasty_%0d", i), 8'h40 + 8'(i), 4'd7, 3'd0, (i < 3) ? 3'(i + 1) : 3'd3);
    idle(1);

    // Out of range and idle.
    clear_reqs();
    cop_req = 1'b1;
    slot("oor_cop", 8'hE5, 4'd0, 3'd0, 3'd0);
    slot("ref_e2", 8'hE2, 4'd1, 3'd0, 3'd0);
    cop_req = 1'b0;
    slot("no_req", 8'h60, 4'd0, 3'd0, 3'd0);
    idle(1);

    // Reset mid-line.
    blt_req = 1'b1; cpu_req = 1'b1; bltpri = 1'b1;
    slot("pre_reset_blt", 8'h50, 4'd7, 3'd0, 3'd1);
    slot("pre_reset_blt2", 8'h52, 4'd7, 3'd0, 3'd2);
    slot_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_out("reset_drop", 4'd0, 3'd0, 3'd0);
    idle(3);
    check_out("reset_hold", 4'd0, 3'd0, 3'd0);
    slot("post_reset", 8'h50, 4'd7, 3'd0, 3'd1);
    idle(2);

    if (sb_q.size() != 0) check("sb_leftover", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_slot_arbiter.md
Name: dma_slot_arbiter

Overview:
- Allocates each chip-bus CCK slot to one DMA channel or to the CPU.
- Slot position comes from the horizontal beam counter (hpos[8:1], 0..226 per line).
- Fixed-slot channels (refresh, disk, audio, sprite) own predetermined slots; remaining slots go by priority to bitplane, copper, blitter and CPU, with CPU starvation relief.
- Sits between the beam counter and the Agnus DMA engines / chip-RAM address mux.

Parameters:
- SLOT_MAX, 226, last valid slot index per line (htotal).
- CPU_STARVE, 3, consecutive blitter grants over a waiting CPU before the CPU is forced in.

Ports:
- clk  in  1  bus clock
- reset  in  1  synchronous, active-high reset
- slot_en  in  1  one-clk strobe per CCK slot; hpos valid in the same clk
- hpos  in  8  current slot index (beam counter hpos[8:1])
- dma_en  in  1  DMACON master enable
- dsk_req  in  1  disk DMA request
- aud_req  in  4  audio channel 0..3 requests
- spr_req  in  8  sprite 0..7 requests
- bpl_req  in  1  bitplane fetch request for this slot
- cop_req  in  1  copper request
- blt_req  in  1  blitter request
- bltpri  in  1  blitter-nasty; disables CPU starvation relief
- cpu_req  in  1  CPU chip-bus request
- owner  out  4  slot owner: 0 idle, 1 refresh, 2 disk, 3 audio, 4 sprite, 5 bitplane, 6 copper, 7 blitter, 8 cpu
- owner_idx  out  3  audio/sprite channel number, else 0
- gnt_bpl, gnt_cop, gnt_blt, gnt_cpu  out  1 each  decoded grants (owner==5/6/7/8)
- cpu_wait  out  3  current starvation count

Behaviour:
- All requests and hpos are sampled only on slot_en. Outputs are registered: valid from the clk after slot_en and held until the next slot_en. Latency 1 clk.
- Reset: owner=0, owner_idx=0, all grants 0, cpu_wait=0. Reset mid-line drops any grant in the next clk. The first slot_en after reset arbitrates normally.
- Fixed map (h = hpos):
  - Refresh: h in {0x01,0x03,0x05,0xE2}. Always granted, independent of dma_en.
  - Disk: h in {0x07,0x09,0x0B}, if dsk_req & dma_en.
  - Audio n: h = 0x0D+2n, if aud_req[n] & dma_en.
  - Sprite n: h in {0x15+4n, 0x17+4n}, if spr_req[n] & dma_en.
- A fixed slot whose owner does not claim it becomes a free slot.
- Bitplane overrides sprite slots: bpl_req & dma_en in a sprite slot grants owner=5. Bitplane never overrides refresh, disk or audio slots.
- Free-slot priority: bitplane > copper > blitter > CPU. Copper is eligible only when h[0]==0.
  - dma_en=0 makes bitplane, copper and blitter ineligible. The CPU is always eligible.
- Starvation relief:
  - cpu_wait increments, saturating at CPU_STARVE, on each slot granted to the blitter while cpu_req=1.
  - While bltpri=0 and cpu_wait==CPU_STARVE, a slot that would go to the blitter goes to the CPU instead.
  - cpu_wait clears when the CPU is granted, when cpu_req=0 at slot_en, or on reset.
  - bltpri=1: the counter still counts, but the override is suppressed.
- h > SLOT_MAX: treated as a free slot with copper ineligible.
- No requests: owner=0.
- Exactly one owner per slot, and grants are mutually exclusive (checked by assertion).
- slot_en in consecutive clks is legal; each strobe is arbitrated independently.

Test Plan:
- Refresh with dma_en=0, h=0x03 and all requests high -> owner=1; h=0x04 -> owner=8 (CPU).
- Audio and sprite: aud_req=4'b0100, h=0x11 -> owner=3, idx=2. spr_req[5]=1, h=0x29 -> owner=4, idx=5. Same slot with bpl_req=1 -> owner=5.
- Copper parity: cop_req=1, blt_req=1, h=0x40 -> owner=6; h=0x41 -> owner=7.
- Starvation: blt_req=cpu_req=1, bltpri=0, free slots 0x40..0x47 -> owners 7,7,7,8,7,7,7,8 and cpu_wait 1,2,3,0,... With bltpri=1 -> all 7, cpu_wait saturates at 3.
- Out of range and idle: h=0xE5 with cop_req only -> owner=0. h=0xE2 -> owner=1.
- Reset: assert reset while owner=7 -> next clk owner=0, cpu_wait=0. Outputs hold without slot_en; first slot_en after reset gives a correct grant.
